// File: rtl/unidade_busca.sv
// rtl/unidade_busca.sv - instruction fetch unit: program counter, next-PC selection and retired-instruction counter
module unidade_busca #(
  parameter logic [31:0] PC_INICIAL  = 32'h00000000,
  parameter int          LARGURA_END = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            instrucao,
  input  logic                   parar,
  input  logic                   desvio,
  input  logic                   salto_reg,
  input  logic [31:0]            imediato,
  input  logic [31:0]            rs1,
  output logic [LARGURA_END-1:0] endereco,
  output logic [31:0]            pc,
  output logic [31:0]            pc_mais4,
  output logic                   instrucao_valida,
  output logic                   parado,
  output logic                   erro_alinhamento,
  output logic [31:0]            contador_instrucoes
);

  typedef enum logic [1:0] {INICIO, EXECUTANDO, PARADO, ERRO} estado_t;

  localparam logic [31:0] EBREAK = 32'h00100073;

  estado_t     estado, prox_estado;
  logic [31:0] pc_reg, prox_pc;
  logic [31:0] contador, prox_contador;
  logic [31:0] alvo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado   <= INICIO;
      pc_reg   <= PC_INICIAL;
      contador <= 32'd0;
    end else begin
      estado   <= prox_estado;
      pc_reg   <= prox_pc;
      contador <= prox_contador;
    end
  end

  always_comb begin
    prox_estado   = estado;
    prox_pc       = pc_reg;
    prox_contador = contador;
    // jalr has priority over a taken branch when both are asserted
    alvo = pc_reg + 32'd4;
    if (salto_reg)
      alvo = (rs1 + imediato) & 32'hFFFFFFFE;
    else if (desvio)
      alvo = pc_reg + imediato;

    case (estado)
      INICIO: prox_estado = EXECUTANDO;
      EXECUTANDO: begin
        if (!parar) begin
          if (instrucao == EBREAK)
            prox_estado = PARADO;
          else if (alvo[1:0] != 2'b00)
            prox_estado = ERRO;
          else begin
            prox_pc = alvo;
            if (contador != 32'hFFFFFFFF)
              prox_contador = contador + 32'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // outputs depend only on registered state, except the valid strobe which gates on parar
  assign pc                  = pc_reg;
  assign pc_mais4            = pc_reg + 32'd4;
  assign endereco            = pc_reg[LARGURA_END+1:2];
  assign contador_instrucoes = contador;
  assign instrucao_valida    = (estado == EXECUTANDO) && !parar;
  assign parado              = (estado == PARADO);
  assign erro_alinhamento    = (estado == ERRO);

endmodule
